// File: rtl/sha256_round_sequencer.sv
// Control FSM sequencing one SHA-256 compression: INIT load, ROUNDS round strobes, final hash add, done pulse.
// Optional macro SHA_SEQ_STALL_EN adds a stall input that freezes the round counter during ROUND.
module sha256_round_sequencer #(
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
`ifdef SHA_SEQ_STALL_EN
  input  logic       stall,
`endif
  output logic       busy,
  output logic       done,
  output logic [5:0] k_addr,
  output logic       round_en,
  output logic       load_init,
  output logic       w_sel_msg,
  output logic [3:0] msg_idx,
  output logic       final_add,
  output logic [2:0] dbg_state
);

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] round;
  logic          hold;
  logic          in_round;
  logic [5:0]    round_ext;

`ifdef SHA_SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // abort wins over every transition, including a pending stall or start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      round <= '0;
    end else if (abort) begin
      state <= IDLE;
      round <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= INIT;
        end
        INIT: begin
          round <= '0;
          state <= ROUND;
        end
        ROUND: begin
          if (!hold) begin
            if (round == LAST_ROUND) begin
              round <= '0;
              state <= FINAL;
            end else begin
              round <= round + CW'(1);
            end
          end
        end
        FINAL: state <= DONE;
        DONE:  state <= IDLE;
        default: begin
          state <= IDLE;
          round <= '0;
        end
      endcase
    end
  end

  // Outputs decode only registered state and counter; round_en is additionally gated by stall.
  assign in_round  = (state == ROUND);
  assign round_ext = 6'(round);

  assign busy      = (state == INIT) || (state == ROUND) || (state == FINAL);
  assign done      = (state == DONE);
  assign load_init = (state == INIT);
  assign final_add = (state == FINAL);
  assign round_en  = in_round && !hold;
  assign k_addr    = in_round ? round_ext : 6'd0;
  assign w_sel_msg = in_round && (int'(round) < MSG_WORDS);
  assign msg_idx   = w_sel_msg ? round_ext[3:0] : 4'd0;
  assign dbg_state = state;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Directed bench for sha256_round_sequencer: vector table plus hand-written corner sequences.
// Stall sequence is compiled only with SHA_SEQ_STALL_EN.
module tb_sha256_round_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
`ifdef SHA_SEQ_STALL_EN
  logic       stall;
`endif
  logic       busy;
  logic       done;
  logic [5:0] k_addr;
  logic       round_en;
  logic       load_init;
  logic       w_sel_msg;
  logic [3:0] msg_idx;
  logic       final_add;
  logic [2:0] dbg_state;
  logic [31:0] out_bus;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];

  sha256_round_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
`ifdef SHA_SEQ_STALL_EN
    .stall     (stall),
`endif
    .busy      (busy),
    .done      (done),
    .k_addr    (k_addr),
    .round_en  (round_en),
    .load_init (load_init),
    .w_sel_msg (w_sel_msg),
    .msg_idx   (msg_idx),
    .final_add (final_add),
    .dbg_state (dbg_state)
  );

  assign out_bus = {16'h0, busy, done, k_addr, round_en, load_init, w_sel_msg, msg_idx, final_add};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks and helpers
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] pk(input logic b, input logic d, input logic [5:0] k,
                                     input logic re, input logic li, input logic ws,
                                     input logic [3:0] mi, input logic fa);
    return {16'h0, b, d, k, re, li, ws, mi, fa};
  endfunction

  // Expected outputs rel cycles after the INIT cycle of a default 64-round compression.
  function automatic logic [31:0] exp_rel(input int rel);
    logic [5:0] k;
    logic       ws;
    k  = 6'd0;
    ws = 1'b0;
    if (rel == 0) return pk(1, 0, 6'd0, 0, 1, 0, 4'd0, 0);
    if (rel >= 1 && rel <= 64) begin
      k  = 6'(rel - 1);
      ws = (rel - 1) < 16;
      return pk(1, 0, k, 1, 0, ws, ws ? k[3:0] : 4'd0, 0);
    end
    if (rel == 65) return pk(1, 0, 6'd0, 0, 0, 0, 4'd0, 1);
    if (rel == 66) return pk(0, 1, 6'd0, 0, 0, 0, 4'd0, 0);
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic        abort;
    int          n;
    logic [31:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  logic [31:0] idle_v;
  int          cyc;
  int          n_done;

  initial begin
    idle_v = 32'h0;

    // {start, abort, cycles to advance, expected outputs, name}
    tbl[0]  = '{1'b0, 1'b0, 1,  idle_v,                                 "idle_after_reset"};
    tbl[1]  = '{1'b1, 1'b0, 1,  pk(1, 0, 6'd0, 0, 1, 0, 4'd0, 0),       "c1_init"};
    tbl[2]  = '{1'b0, 1'b0, 1,  pk(1, 0, 6'd0, 1, 0, 1, 4'd0, 0),       "c2_round0"};
    tbl[3]  = '{1'b0, 1'b0, 15, pk(1, 0, 6'd15, 1, 0, 1, 4'd15, 0),     "c17_round15_msg"};
    tbl[4]  = '{1'b0, 1'b0, 1,  pk(1, 0, 6'd16, 1, 0, 0, 4'd0, 0),      "c18_round16_sched"};
    tbl[5]  = '{1'b0, 1'b0, 47, pk(1, 0, 6'd63, 1, 0, 0, 4'd0, 0),      "c65_round63"};
    tbl[6]  = '{1'b0, 1'b0, 1,  pk(1, 0, 6'd0, 0, 0, 0, 4'd0, 1),       "c66_final"};
    tbl[7]  = '{1'b0, 1'b0, 1,  pk(0, 1, 6'd0, 0, 0, 0, 4'd0, 0),       "c67_done"};
    tbl[8]  = '{1'b0, 1'b0, 1,  idle_v,                                 "c68_idle"};
    tbl[9]  = '{1'b1, 1'b0, 1,  exp_rel(0),                             "abort_run_init"};
    tbl[10] = '{1'b0, 1'b0, 41, pk(1, 0, 6'd40, 1, 0, 0, 4'd0, 0),      "abort_run_round40"};
    tbl[11] = '{1'b0, 1'b1, 1,  idle_v,                                 "abort_to_idle"};
    tbl[12] = '{1'b0, 1'b0, 5,  idle_v,                                 "abort_stays_idle"};
    tbl[13] = '{1'b0, 1'b1, 1,  idle_v,                                 "abort_in_idle_noop"};
    tbl[14] = '{1'b1, 1'b0, 1,  exp_rel(0),                             "restart_init"};
    tbl[15] = '{1'b0, 1'b0, 31, pk(1, 0, 6'd30, 1, 0, 0, 4'd0, 0),      "restart_round30"};
    tbl[16] = '{1'b1, 1'b0, 1,  pk(1, 0, 6'd31, 1, 0, 0, 4'd0, 0),      "start_ignored_r31"};
    tbl[17] = '{1'b0, 1'b0, 1,  pk(1, 0, 6'd32, 1, 0, 0, 4'd0, 0),      "start_ignored_r32"};
    tbl[18] = '{1'b0, 1'b0, 32, pk(1, 0, 6'd0, 0, 0, 0, 4'd0, 1),       "restart_final"};
    tbl[19] = '{1'b0, 1'b0, 1,  pk(0, 1, 6'd0, 0, 0, 0, 4'd0, 0),       "restart_done"};
    tbl[20] = '{1'b0, 1'b0, 1,  idle_v,                                 "restart_idle"};
    tbl[21] = '{1'b0, 1'b0, 1,  idle_v,                                 "start_not_queued"};

    // reset: outputs must be zero before any clock edge
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
`ifdef SHA_SEQ_STALL_EN
    stall = 1'b0;
`endif
    #3;
    check("reset_outputs", out_bus, idle_v);
    check("reset_state", 32'(dbg_state), 32'd0);
    repeat (3) @(posedge clk);
    #5 rst = 1'b1;
    step(1);

    // vector table
    for (int i = 0; i < NV; i++) begin
      start = tbl[i].start;
      abort = tbl[i].abort;
      step(1);
      start = 1'b0;
      abort = 1'b0;
      if (tbl[i].n > 1) step(tbl[i].n - 1);
      check(tbl[i].name, out_bus, tbl[i].exp);
    end

    // start held: back-to-back compressions, one IDLE cycle between done and INIT
    for (int c = 1; c <= 204; c++) exp_q.push_back(exp_rel((c - 1) % 68));
    n_done = 0;
    start  = 1'b1;
    for (int c = 1; c <= 204; c++) begin
      logic [31:0] e;
      step(1);
      if (c == 200) start = 1'b0;
      if (done) n_done++;
      e = exp_q.pop_front();
      check($sformatf("held_start_c%0d", c), out_bus, e);
    end
    check("held_start_done_count", 32'(n_done), 32'd3);
    step(1);
    check("held_start_release_idle", out_bus, idle_v);

    // asynchronous reset mid-operation at k_addr = 20
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(21);
    check("pre_reset_round20", out_bus, pk(1, 0, 6'd20, 1, 0, 0, 4'd0, 0));
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs", out_bus, idle_v);
    step(2);
    #3 rst = 1'b1;
    step(3);
    check("after_reset_idle", out_bus, idle_v);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("after_reset_start_init", out_bus, exp_rel(0));
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_from_init", out_bus, idle_v);

`ifdef SHA_SEQ_STALL_EN
    // three stall cycles at k_addr = 10 stretch the compression to 70 cycles
    start = 1'b1;
    step(1);
    start = 1'b0;
    cyc = 1;
    step(11);
    cyc = 12;
    check("stall_pre_round10", out_bus, pk(1, 0, 6'd10, 1, 0, 1, 4'd10, 0));
    stall = 1'b1;
    #1;
    check("stall_c12", out_bus, pk(1, 0, 6'd10, 0, 0, 1, 4'd10, 0));
    step(1);
    cyc = 13;
    check("stall_c13", out_bus, pk(1, 0, 6'd10, 0, 0, 1, 4'd10, 0));
    step(1);
    cyc = 14;
    check("stall_c14", out_bus, pk(1, 0, 6'd10, 0, 0, 1, 4'd10, 0));
    step(1);
    cyc = 15;
    stall = 1'b0;
    check("stall_released_c15", out_bus, pk(1, 0, 6'd10, 1, 0, 1, 4'd10, 0));
    while (!done && cyc < 90) begin
      step(1);
      cyc++;
    end
    check("stall_done_cycle", 32'(cyc), 32'd70);
    step(1);
    check("stall_idle_after_done", out_bus, idle_v);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
